icache_refill_engine: RTL and testbench
=======================================

# icache_refill_engine

Parametrised successor to the instruction-cache miss handler. It accepts one miss at a time, fetches the full block from memory as a burst of beats, and returns the missed word early, as soon as its beat arrives. It then writes the block into the data array in chunks and finally commits the tag/valid metadata for the chosen victim way. It sits between the cache lookup stage and the memory, data-array and tag/status-array interfaces.

## Interface
- TAG_W, 8, tag bits per address
- SET_W, 4, set index bits
- OFF_W, 4, word-offset bits; WORDS = 2**OFF_W words per block
- WORD_W, 20, instruction word width
- BEAT_W, 40, memory beat width; WPB = BEAT_W/WORD_W words per beat; BEATS = WORDS/WPB
- NUM_WAYS, 4, associativity; WAY_W = $clog2(NUM_WAYS)
- DA_WR_WORDS, 4, words per data-array write; CHUNKS = WORDS/DA_WR_WORDS; CH_W = $clog2(CHUNKS)
- Legal configurations: BEAT_W % WORD_W == 0, WORDS % WPB == 0, WORDS % DA_WR_WORDS == 0, CHUNKS >= 2, BEATS >= 2. Illegal configurations are a build-time error.

Ports:
- clk  in  1  clock, all state updates on posedge
- arst_n  in  1  reset, asynchronous, active-low
- i_req_valid / o_req_ready  in/out  1  miss request handshake
- i_tag, i_set, i_offset  in  TAG_W, SET_W, OFF_W  missed address fields
- i_valid_bits  in  NUM_WAYS  valid bits of the missed set
- i_lru_way  in  WAY_W  LRU way of the missed set
- o_mem_req_valid / i_mem_req_ready  out/in  1  memory request handshake
- o_mem_req_addr  out  TAG_W+SET_W  block address {tag,set}
- i_mem_data_valid, i_mem_data  in  1, BEAT_W  in-order beats 0..BEATS-1; no backpressure
- o_da_valid / i_da_ready  out/in  1  data-array write handshake
- o_da_set, o_da_way, o_da_chunk, o_da_data  out  SET_W, WAY_W, CH_W, DA_WR_WORDS*WORD_W
- o_meta_valid / i_meta_ready  out/in  1  tag+valid commit handshake
- o_meta_set, o_meta_way, o_meta_tag  out  SET_W, WAY_W, TAG_W
- o_word_valid, o_word  out  1, WORD_W  early-restart missed word, single-cycle pulse
- o_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, REQ, FILL, DA_WR, META.
- IDLE: o_req_ready=1. On i_req_valid, capture tag/set/offset and the victim way, then go to REQ.
- Victim selection: the lowest-indexed way whose i_valid_bits bit is 0; if all ways are valid, i_lru_way.
- REQ: o_mem_req_valid=1 with o_mem_req_addr held stable. When i_mem_req_ready=1, go to FILL with beat counter = 0.
- FILL: each i_mem_data_valid stores the beat into line-buffer slot[beat counter] and increments the counter. Within a beat, word k occupies bits [k*WORD_W +: WORD_W]. On the final beat, go to DA_WR with chunk counter = 0.
- Early restart: when the beat holding word i_offset (beat index = i_offset/WPB) is captured, o_word_valid pulses for exactly one cycle on the next cycle. o_word carries that word and holds its value until the next pulse. The pulse occurs exactly once per miss.
- DA_WR: o_da_valid=1 with o_da_chunk = chunk counter and o_da_data = words [chunk*DA_WR_WORDS +: DA_WR_WORDS], lowest word in the LSBs. The counter advances on each handshake. After chunk CHUNKS-1, go to META.
- META: o_meta_valid=1. On the handshake, go to IDLE. Metadata is committed only after all data chunks, so a partially written block is never marked valid.
- i_mem_data_valid outside FILL is ignored. New requests are not accepted outside IDLE.

## Timing
- Reset: state IDLE; counters 0; captured fields 0; o_req_ready=1; every other output 0; line buffer need not be cleared.
- Reset mid-operation: abort immediately to reset values. No further memory, DA or meta outputs are issued for the aborted miss.
- Cycle map with all readies high and back-to-back beats (defaults):
  - accept at edge 0
  - REQ in cycle 1
  - FILL in cycles 2-9, beats arriving in cycles 2-9
  - DA_WR in cycles 10-13
  - META in cycle 14
  - o_req_ready=1 in cycle 15
- Missed-word latency: one cycle after its beat. Offset 0 pulses in cycle 3.
- The valid/data/addr outputs of every handshake remain stable while their ready is low.
- A gap in beats stalls FILL with no other effect.

## Test plan
- Reset, then miss tag=0xA5 set=3 offset=5 with i_valid_bits=4'b1111, lru=2, all ready, beats 0-7 back-to-back:
  - o_mem_req_addr=0xA53
  - o_word_valid in cycle 5 with word 5
  - 4 DA writes, chunks 0-3, to way 2
  - meta {set 3, way 2, tag 0xA5}
  - o_req_ready in cycle 15
- i_valid_bits=4'b1011 with lru=0 -> victim way 2. i_valid_bits=4'b0000 -> way 0.
- offset=15 with beats arriving 3 cycles apart -> o_word_valid fires one cycle after beat 7, before any DA write.
- i_mem_req_ready low for 5 cycles, i_da_ready toggling, i_meta_ready low for 3 cycles:
  - outputs hold stable
  - chunk order is preserved
  - exactly one meta commit
- arst_n asserted mid-FILL (after beat 3) -> all outputs reset. A following miss completes normally, with no stale DA or meta writes.
- i_req_valid held high throughout a miss and spurious i_mem_data_valid in IDLE -> only one request accepted per IDLE visit; spurious beats are ignored.

Source files
------------

// File: rtl/icache_refill_engine.sv
// Instruction-cache miss refill engine: fetches a block as a burst, returns the
// missed word early, writes the block into the data array in chunks, then commits tag/valid.
module icache_refill_engine #(
    parameter int TAG_W       = 8,
    parameter int SET_W       = 4,
    parameter int OFF_W       = 4,
    parameter int WORD_W      = 20,
    parameter int BEAT_W      = 40,
    parameter int NUM_WAYS    = 4,
    parameter int DA_WR_WORDS = 4,
    localparam int WAY_W      = $clog2(NUM_WAYS),
    localparam int CH_W       = $clog2((2**OFF_W) / DA_WR_WORDS)
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [TAG_W-1:0]              i_tag,
    input  logic [SET_W-1:0]              i_set,
    input  logic [OFF_W-1:0]              i_offset,
    input  logic [NUM_WAYS-1:0]           i_valid_bits,
    input  logic [WAY_W-1:0]              i_lru_way,
    output logic                          o_mem_req_valid,
    input  logic                          i_mem_req_ready,
    output logic [TAG_W+SET_W-1:0]        o_mem_req_addr,
    input  logic                          i_mem_data_valid,
    input  logic [BEAT_W-1:0]             i_mem_data,
    output logic                          o_da_valid,
    input  logic                          i_da_ready,
    output logic [SET_W-1:0]              o_da_set,
    output logic [WAY_W-1:0]              o_da_way,
    output logic [CH_W-1:0]               o_da_chunk,
    output logic [DA_WR_WORDS*WORD_W-1:0] o_da_data,
    output logic                          o_meta_valid,
    input  logic                          i_meta_ready,
    output logic [SET_W-1:0]              o_meta_set,
    output logic [WAY_W-1:0]              o_meta_way,
    output logic [TAG_W-1:0]              o_meta_tag,
    output logic                          o_word_valid,
    output logic [WORD_W-1:0]             o_word,
    output logic                          o_busy
);
    localparam int WORDS   = 2**OFF_W;
    localparam int WPB     = BEAT_W / WORD_W;
    localparam int BEATS   = WORDS / WPB;
    localparam int CHUNKS  = WORDS / DA_WR_WORDS;
    localparam int BT_W    = $clog2(BEATS);
    localparam int DA_BITS = DA_WR_WORDS * WORD_W;

    if ((BEAT_W % WORD_W) != 0 || (WORDS % WPB) != 0 || (WORDS % DA_WR_WORDS) != 0 ||
        CHUNKS < 2 || BEATS < 2) begin : g_bad_cfg
        $error("icache_refill_engine: illegal parameter configuration");
    end

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DA_WR, S_META} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TAG_W-1:0]    r_tag;
    logic [SET_W-1:0]    r_set;
    logic [OFF_W-1:0]    r_offset;
    logic [WAY_W-1:0]    r_way;
    logic [BT_W-1:0]     r_beat_cnt;
    logic [CH_W-1:0]     r_chunk;
    logic                r_word_valid;
    logic [WORD_W-1:0]   r_word;
    logic [BEAT_W-1:0]   r_line [BEATS];

    logic [WAY_W-1:0]         w_victim;
    logic [BT_W-1:0]          w_tgt_beat;
    logic [OFF_W-1:0]         w_tgt_sub;
    logic [WORD_W-1:0]        w_word_in;
    logic [WORDS*WORD_W-1:0]  w_line;
    logic [DA_BITS-1:0]       w_da_data;
    logic                     w_capture;
    logic                     w_hit;

    // Victim way, missed-word extraction and chunk selection from the line buffer.
    always_comb begin
        w_victim = i_lru_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            w_victim = (!i_valid_bits[w]) ? WAY_W'(w) : w_victim;
        end
        w_tgt_beat = BT_W'(r_offset / OFF_W'(WPB));
        w_tgt_sub  = r_offset % OFF_W'(WPB);
        w_word_in  = '0;
        for (int k = 0; k < WPB; k++) begin
            w_word_in = (w_tgt_sub == OFF_W'(k)) ? i_mem_data[k*WORD_W +: WORD_W] : w_word_in;
        end
        w_line = '0;
        for (int b = 0; b < BEATS; b++) begin
            w_line[b*BEAT_W +: BEAT_W] = r_line[b];
        end
        w_da_data = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            w_da_data = (r_chunk == CH_W'(c)) ? w_line[c*DA_BITS +: DA_BITS] : w_da_data;
        end
        w_capture = (r_state == S_FILL) && i_mem_data_valid;
        w_hit     = w_capture && (r_beat_cnt == w_tgt_beat);
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next          = r_state;
        o_req_ready     = 1'b0;
        o_mem_req_valid = 1'b0;
        o_da_valid      = 1'b0;
        o_meta_valid    = 1'b0;
        o_da_data       = '0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                w_next      = i_req_valid ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                w_next          = i_mem_req_ready ? S_FILL : S_REQ;
            end
            S_FILL: begin
                w_next = (w_capture && r_beat_cnt == BT_W'(BEATS - 1)) ? S_DA_WR : S_FILL;
            end
            S_DA_WR: begin
                o_da_valid = 1'b1;
                o_da_data  = w_da_data;
                w_next     = (i_da_ready && r_chunk == CH_W'(CHUNKS - 1)) ? S_META : S_DA_WR;
            end
            S_META: begin
                o_meta_valid = 1'b1;
                w_next       = i_meta_ready ? S_IDLE : S_META;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_mem_req_addr = {r_tag, r_set};
    assign o_da_set       = r_set;
    assign o_da_way       = r_way;
    assign o_da_chunk     = r_chunk;
    assign o_meta_set     = r_set;
    assign o_meta_way     = r_way;
    assign o_meta_tag     = r_tag;
    assign o_word_valid   = r_word_valid;
    assign o_word         = r_word;
    assign o_busy         = (r_state != S_IDLE);

    // State, captured miss fields, counters and the early-restart word.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_set        <= '0;
            r_offset     <= '0;
            r_way        <= '0;
            r_beat_cnt   <= '0;
            r_chunk      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_state      <= w_next;
            r_word_valid <= w_hit;
            if (w_hit) begin
                r_word <= w_word_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_tag      <= i_tag;
                        r_set      <= i_set;
                        r_offset   <= i_offset;
                        r_way      <= w_victim;
                        r_beat_cnt <= '0;
                        r_chunk    <= '0;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_beat_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (w_capture) begin
                        r_beat_cnt <= r_beat_cnt + BT_W'(1);
                        r_chunk    <= '0;
                    end
                end
                S_DA_WR: begin
                    if (i_da_ready) begin
                        r_chunk <= r_chunk + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line buffer carries no reset; every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_line[r_beat_cnt] <= i_mem_data;
        end
    end
endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed, table-driven bench for icache_refill_engine with hand-written
// sequences for stalls, beat gaps, mid-fill reset and spurious inputs.
module tb_icache_refill_engine;
    logic        clk, arst_n;
    logic        i_req_valid, o_req_ready;
    logic [7:0]  i_tag;
    logic [3:0]  i_set, i_offset, i_valid_bits;
    logic [1:0]  i_lru_way;
    logic        o_mem_req_valid, i_mem_req_ready;
    logic [11:0] o_mem_req_addr;
    logic        i_mem_data_valid;
    logic [39:0] i_mem_data;
    logic        o_da_valid, i_da_ready;
    logic [3:0]  o_da_set;
    logic [1:0]  o_da_way, o_da_chunk;
    logic [79:0] o_da_data;
    logic        o_meta_valid, i_meta_ready;
    logic [3:0]  o_meta_set;
    logic [1:0]  o_meta_way;
    logic [7:0]  o_meta_tag;
    logic        o_word_valid;
    logic [19:0] o_word;
    logic        o_busy;

    icache_refill_engine dut (
        .clk(clk), .arst_n(arst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_tag(i_tag), .i_set(i_set), .i_offset(i_offset),
        .i_valid_bits(i_valid_bits), .i_lru_way(i_lru_way),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr),
        .i_mem_data_valid(i_mem_data_valid), .i_mem_data(i_mem_data),
        .o_da_valid(o_da_valid), .i_da_ready(i_da_ready),
        .o_da_set(o_da_set), .o_da_way(o_da_way), .o_da_chunk(o_da_chunk), .o_da_data(o_da_data),
        .o_meta_valid(o_meta_valid), .i_meta_ready(i_meta_ready),
        .o_meta_set(o_meta_set), .o_meta_way(o_meta_way), .o_meta_tag(o_meta_tag),
        .o_word_valid(o_word_valid), .o_word(o_word), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] wordv(input logic [11:0] seed, input int w);
        logic [3:0] idx;
        idx = 4'(w);
        return {seed, idx, 4'h9};
    endfunction

    function automatic logic [39:0] beatv(input logic [11:0] seed, input int b);
        return {wordv(seed, 2*b+1), wordv(seed, 2*b)};
    endfunction

    function automatic logic [79:0] chunkv(input logic [11:0] seed, input int c);
        logic [79:0] r;
        for (int j = 0; j < 4; j++) r[j*20 +: 20] = wordv(seed, 4*c + j);
        return r;
    endfunction

    // Monitor state
    int n_acc, acc_cyc, n_memreq, memreq_cyc, n_word, word_cyc, n_da, first_da_cyc, n_meta, meta_cyc;
    logic [11:0] memreq_addr;
    logic [19:0] word_val;
    logic        word_before_da;
    logic [1:0]  q_chunk[$];
    logic [1:0]  q_way[$];
    logic [3:0]  q_set[$];
    logic [79:0] q_data[$];
    logic [13:0] meta_rec;
    logic        p_mem, p_da, p_meta;
    logic [11:0] s_addr;
    logic [87:0] s_da;
    logic [13:0] s_meta;
    int          meta_hold = 0, meta_low = 0;
    logic        da_toggle = 1'b0;

    task automatic clear_mon();
        n_acc = 0; n_memreq = 0; n_word = 0; n_da = 0; n_meta = 0;
        acc_cyc = 0; memreq_cyc = -1; word_cyc = -1; first_da_cyc = -1; meta_cyc = -1;
        word_before_da = 1'b0;
        q_chunk.delete(); q_way.delete(); q_set.delete(); q_data.delete();
    endtask

    always @(negedge clk) begin
        if (!arst_n) begin
            p_mem = 1'b0; p_da = 1'b0; p_meta = 1'b0;
        end else begin
            if (p_mem)  check_eq("mem_req_hold", 96'({o_mem_req_valid, o_mem_req_addr}), 96'({1'b1, s_addr}));
            if (p_da)   check_eq("da_hold", 96'({o_da_valid, o_da_chunk, o_da_way, o_da_set, o_da_data}), 96'({1'b1, s_da}));
            if (p_meta) check_eq("meta_hold", 96'({o_meta_valid, o_meta_set, o_meta_way, o_meta_tag}), 96'({1'b1, s_meta}));
            p_mem  = o_mem_req_valid && !i_mem_req_ready;
            s_addr = o_mem_req_addr;
            p_da   = o_da_valid && !i_da_ready;
            s_da   = {o_da_chunk, o_da_way, o_da_set, o_da_data};
            p_meta = o_meta_valid && !i_meta_ready;
            s_meta = {o_meta_set, o_meta_way, o_meta_tag};
            if (o_req_ready && i_req_valid) begin n_acc++; acc_cyc = cyc; end
            if (o_mem_req_valid && i_mem_req_ready) begin
                n_memreq++; memreq_addr = o_mem_req_addr; memreq_cyc = cyc - acc_cyc;
            end
            if (o_word_valid) begin
                n_word++; word_val = o_word; word_cyc = cyc - acc_cyc; word_before_da = (n_da == 0);
            end
            if (o_da_valid && i_da_ready) begin
                if (n_da == 0) first_da_cyc = cyc - acc_cyc;
                n_da++;
                q_chunk.push_back(o_da_chunk); q_way.push_back(o_da_way);
                q_set.push_back(o_da_set); q_data.push_back(o_da_data);
            end
            if (o_meta_valid && i_meta_ready) begin
                n_meta++; meta_cyc = cyc - acc_cyc;
                meta_rec = {o_meta_set, o_meta_way, o_meta_tag};
            end
        end
    end

    // Data-array and meta ready patterns
    always @(posedge clk) begin
        #1;
        i_da_ready = da_toggle ? ~i_da_ready : 1'b1;
        if (o_meta_valid && meta_low < meta_hold) begin
            i_meta_ready = 1'b0;
            meta_low++;
        end else begin
            i_meta_ready = 1'b1;
        end
    end

    int done_cyc;

    task automatic do_miss(input logic [7:0] tag, input logic [3:0] set, input logic [3:0] off,
                           input logic [3:0] vb, input logic [1:0] lru, input logic [11:0] seed,
                           input int gap, input int req_hold, input bit keep_req, input bit spur,
                           input int abort_after, input int mhold, input bit dtog);
        clear_mon();
        meta_low = 0; meta_hold = mhold; da_toggle = dtog;
        if (spur) begin
            for (int s = 0; s < 3; s++) begin
                i_mem_data_valid = 1'b1; i_mem_data = 40'hBAD0_0000_00 | 40'(s);
                @(posedge clk); #1;
            end
            i_mem_data_valid = 1'b0;
        end
        i_req_valid = 1'b1; i_tag = tag; i_set = set; i_offset = off;
        i_valid_bits = vb; i_lru_way = lru;
        i_mem_req_ready = (req_hold == 0);
        @(posedge clk); #1;
        if (!keep_req) i_req_valid = 1'b0;
        for (int h = 0; h < req_hold; h++) begin @(posedge clk); #1; end
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            i_mem_data_valid = 1'b1; i_mem_data = beatv(seed, b);
            @(posedge clk); #1;
            i_mem_data_valid = 1'b0;
            if (b == abort_after) begin
                arst_n = 1'b0;
                return;
            end
        end
        for (int k = 0; k < 200; k++) begin
            if (o_req_ready) break;
            if (spur) begin i_mem_data_valid = 1'b1; i_mem_data = ~beatv(seed, k % 8); end
            @(posedge clk); #1;
        end
        i_mem_data_valid = 1'b0;
        i_req_valid = 1'b0;
        done_cyc = cyc - acc_cyc;
        check_eq("done_within_budget", 96'(o_req_ready), 96'(1'b1));
    endtask

    task automatic check_miss(input string nm, input logic [7:0] tag, input logic [3:0] set,
                              input logic [3:0] off, input logic [1:0] way, input logic [11:0] seed,
                              input logic [11:0] addr);
        check_eq({nm, "_accepts"}, 96'(n_acc), 96'(1));
        check_eq({nm, "_memreq"}, 96'({n_memreq[3:0], memreq_addr}), 96'({4'd1, addr}));
        check_eq({nm, "_word"}, 96'({n_word[3:0], word_val}), 96'({4'd1, wordv(seed, int'(off))}));
        check_eq({nm, "_da_count"}, 96'(n_da), 96'(4));
        for (int c = 0; c < 4; c++) begin
            if (c < q_data.size()) begin
                check_eq({nm, "_da_hdr"}, 96'({q_chunk[c], q_way[c], q_set[c]}), 96'({2'(c), way, set}));
                check_eq({nm, "_da_data"}, 96'(q_data[c]), 96'(chunkv(seed, c)));
            end
        end
        check_eq({nm, "_meta"}, 96'({n_meta[3:0], meta_rec}), 96'({4'd1, set, way, tag}));
        check_eq({nm, "_idle"}, 96'({o_busy, o_req_ready}), 96'({1'b0, 1'b1}));
    endtask

    task automatic check_reset_outs(input string nm);
        check_eq(nm, 96'({o_req_ready, o_busy, o_mem_req_valid, o_da_valid, o_meta_valid,
                          o_word_valid, o_word, o_mem_req_addr}),
                 96'({1'b1, 5'b0, 20'h0, 12'h0}));
        check_eq({nm, "_fields"}, 96'({o_da_data, o_da_chunk, o_da_way, o_da_set}), 96'(0));
        check_eq({nm, "_meta"}, 96'({o_meta_set, o_meta_way, o_meta_tag}), 96'(0));
    endtask

    typedef struct {
        logic [7:0]  tag;
        logic [3:0]  set;
        logic [3:0]  off;
        logic [3:0]  vb;
        logic [1:0]  lru;
        logic [11:0] seed;
        logic [1:0]  exp_way;
        logic [11:0] exp_addr;
        int          exp_wcyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 4'h3, 4'd5,  4'b1111, 2'd2, 12'h111, 2'd2, 12'hA53, 5};
        vecs[1] = '{8'h3C, 4'h7, 4'd0,  4'b1011, 2'd0, 12'h222, 2'd2, 12'h3C7, 3};
        vecs[2] = '{8'h5E, 4'hF, 4'd15, 4'b0000, 2'd3, 12'h333, 2'd0, 12'h5EF, 10};
        vecs[3] = '{8'h81, 4'hA, 4'd8,  4'b0111, 2'd1, 12'h444, 2'd3, 12'h81A, 7};
        vecs[4] = '{8'hFF, 4'h1, 4'd1,  4'b1101, 2'd0, 12'h555, 2'd1, 12'hFF1, 3};

        arst_n = 1'b0; i_req_valid = 1'b0; i_tag = '0; i_set = '0; i_offset = '0;
        i_valid_bits = '0; i_lru_way = '0; i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0;
        i_mem_data = '0; i_da_ready = 1'b1; i_meta_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset_held");
        arst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outs("reset_released");

        for (int v = 0; v < 5; v++) begin
            do_miss(vecs[v].tag, vecs[v].set, vecs[v].off, vecs[v].vb, vecs[v].lru, vecs[v].seed,
                    0, 0, 1'b0, 1'b0, -1, 0, 1'b0);
            check_miss("vec", vecs[v].tag, vecs[v].set, vecs[v].off, vecs[v].exp_way, vecs[v].seed,
                       vecs[v].exp_addr);
            check_eq("vec_timing", 96'({memreq_cyc[7:0], word_cyc[7:0], first_da_cyc[7:0],
                                        meta_cyc[7:0], done_cyc[7:0]}),
                     96'({8'd1, 8'(vecs[v].exp_wcyc), 8'd10, 8'd14, 8'd15}));
            @(posedge clk); #1;
        end

        // offset 15 with beats three cycles apart
        do_miss(8'h42, 4'h9, 4'd15, 4'b1111, 2'd1, 12'h666, 2, 0, 1'b0, 1'b0, -1, 0, 1'b0);
        check_miss("gap", 8'h42, 4'h9, 4'd15, 2'd1, 12'h666, 12'h429);
        check_eq("gap_timing", 96'({word_before_da, word_cyc[7:0], first_da_cyc[7:0]}),
                 96'({1'b1, 8'd24, 8'd24}));

        // memory-request stall, toggling DA ready, held-off meta ready
        do_miss(8'h17, 4'h2, 4'd0, 4'b0001, 2'd3, 12'h777, 0, 5, 1'b0, 1'b0, -1, 3, 1'b1);
        check_miss("stall", 8'h17, 4'h2, 4'd0, 2'd1, 12'h777, 12'h172);
        check_eq("stall_memreq_cyc", 96'(memreq_cyc), 96'(6));
        da_toggle = 1'b0; meta_hold = 0;
        @(posedge clk); #1;

        // reset asserted after beat 3 (holds the missed word for offset 6)
        do_miss(8'hC3, 4'h5, 4'd6, 4'b1111, 2'd0, 12'h888, 0, 0, 1'b0, 1'b0, 3, 0, 1'b0);
        #1;
        check_reset_outs("abort_reset");
        @(posedge clk); #1;
        arst_n = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_quiet", 96'({n_memreq[3:0], n_word[3:0], n_da[3:0], n_meta[3:0], o_busy}), 96'(0));
        do_miss(8'h6B, 4'hD, 4'd11, 4'b1111, 2'd3, 12'h999, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0);
        check_miss("after_abort", 8'h6B, 4'hD, 4'd11, 2'd3, 12'h999, 12'h6BD);
        @(posedge clk); #1;

        // request held high through the miss; spurious beats in IDLE and after FILL
        do_miss(8'h2D, 4'h4, 4'd3, 4'b1110, 2'd2, 12'hAAA, 0, 0, 1'b1, 1'b1, -1, 0, 1'b0);
        check_miss("spur", 8'h2D, 4'h4, 4'd3, 2'd0, 12'hAAA, 12'h2D4);
        repeat (2) @(posedge clk);
        #1;
        check_eq("spur_idle", 96'({o_busy, o_word_valid}), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
